// File: rtl/uart_rx_gen.sv
// UART receiver with majority-vote sampling, runtime parity/stop configuration,
// break detection and a show-ahead receive FIFO with per-word error flags.
module uart_rx_gen #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               tick_os,
    input  logic                               rx_pin,
    input  logic [1:0]                         parity_mode,
    input  logic                               stop_bits2,
    output logic [DATA_BITS-1:0]               m_data,
    output logic                               m_parity_err,
    output logic                               m_frame_err,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               overrun,
    output logic                               break_det
);

    localparam int SC_W   = $clog2(OVERSAMPLE);
    localparam int BI_W   = $clog2(DATA_BITS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WORD_W = DATA_BITS + 2;

    localparam logic [SC_W-1:0] SC_S0   = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_S1   = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0] SC_VOTE = SC_W'(OVERSAMPLE / 2 + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rx_pin};
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [SC_W-1:0]     sc_q, sc_d;
    logic [BI_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]          smp_q, smp_d;
    logic [1:0]          pmode_q, pmode_d;
    logic                stop2_q, stop2_d;
    logic                par_bit_q, par_bit_d;
    logic                par_err_q, par_err_d;
    logic                frm_err_q, frm_err_d;
    logic                stop1_zero_q, stop1_zero_d;

    logic                vote;
    logic                at_vote;
    logic                at_last;
    logic                par_en;
    logic                last_stop;
    logic                frm_err_now;
    logic                brk_now;
    logic                push;
    logic                brk_pulse;
    logic [WORD_W-1:0]   push_word;

    // Two stored mid-bit samples plus the live one form the three-sample vote.
    assign vote        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
    assign at_vote     = (sc_q == SC_VOTE);
    assign at_last     = (sc_q == SC_LAST);
    assign par_en      = pmode_q[0] ^ pmode_q[1];
    assign last_stop   = (bit_q == {{(BI_W-1){1'b0}}, stop2_q});
    assign frm_err_now = frm_err_q | ~vote;
    assign brk_now     = (shift_q == '0) && (!par_en || !par_bit_q) &&
                         ((bit_q == '0) ? !vote : stop1_zero_q);
    assign push_word   = {shift_q, par_err_q, frm_err_now};

    always_comb begin
        state_d      = state_q;
        sc_d         = sc_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        smp_d        = smp_q;
        pmode_d      = pmode_q;
        stop2_d      = stop2_q;
        par_bit_d    = par_bit_q;
        par_err_d    = par_err_q;
        frm_err_d    = frm_err_q;
        stop1_zero_d = stop1_zero_q;
        push         = 1'b0;
        brk_pulse    = 1'b0;

        if (tick_os) begin
            if (sc_q == SC_S0) smp_d[0] = rx_s;
            if (sc_q == SC_S1) smp_d[1] = rx_s;

            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d      = S_START;
                        sc_d         = SC_W'(1);
                        bit_d        = '0;
                        pmode_d      = parity_mode;
                        stop2_d      = stop_bits2;
                        par_bit_d    = 1'b0;
                        par_err_d    = 1'b0;
                        frm_err_d    = 1'b0;
                        stop1_zero_d = 1'b0;
                    end
                end

                S_START: begin
                    sc_d = sc_q + SC_W'(1);
                    if (at_vote && vote) begin
                        state_d = S_IDLE;
                    end else if (at_last) begin
                        state_d = S_DATA;
                        sc_d    = '0;
                        bit_d   = '0;
                    end
                end

                S_DATA: begin
                    sc_d = sc_q + SC_W'(1);
                    if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    if (at_last) begin
                        sc_d = '0;
                        if (bit_q == BI_LAST) begin
                            bit_d   = '0;
                            state_d = par_en ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + BI_W'(1);
                        end
                    end
                end

                S_PARITY: begin
                    sc_d = sc_q + SC_W'(1);
                    if (at_vote) begin
                        par_bit_d = vote;
                        par_err_d = (pmode_q == 2'b01) ? ^{shift_q, vote} : ~^{shift_q, vote};
                    end
                    if (at_last) begin
                        state_d = S_STOP;
                        sc_d    = '0;
                        bit_d   = '0;
                    end
                end

                S_STOP: begin
                    sc_d = sc_q + SC_W'(1);
                    if (at_vote) begin
                        frm_err_d = frm_err_now;
                        if (bit_q == '0) stop1_zero_d = ~vote;
                        // Leave at the last stop vote so the next start edge is caught early.
                        if (last_stop) begin
                            push      = 1'b1;
                            brk_pulse = brk_now;
                            state_d   = brk_now ? S_BRK_WAIT : S_IDLE;
                        end
                    end else if (at_last) begin
                        sc_d  = '0;
                        bit_d = bit_q + BI_W'(1);
                    end
                end

                S_BRK_WAIT: begin
                    if (rx_s) state_d = S_IDLE;
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              overrun_q, overrun_d;
    logic              brk_q, brk_d;
    logic              do_pop;
    logic              do_push;
    logic              full;
    logic [WORD_W-1:0] head;

    assign full    = (cnt_q == CNT_FULL);
    assign do_pop  = m_ready && (cnt_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        overrun_d = push && full && !do_pop;
        brk_d     = brk_pulse;

        if (do_push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q       <= '1;
            state_q      <= S_IDLE;
            sc_q         <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            smp_q        <= '0;
            pmode_q      <= '0;
            stop2_q      <= 1'b0;
            par_bit_q    <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            stop1_zero_q <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            overrun_q    <= 1'b0;
            brk_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            sc_q         <= sc_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            smp_q        <= smp_d;
            pmode_q      <= pmode_d;
            stop2_q      <= stop2_d;
            par_bit_q    <= par_bit_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            stop1_zero_q <= stop1_zero_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            overrun_q    <= overrun_d;
            brk_q        <= brk_d;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign m_data       = head[WORD_W-1:2];
    assign m_parity_err = head[1];
    assign m_frame_err  = head[0];
    assign m_valid      = (cnt_q != '0);
    assign fifo_count   = cnt_q;
    assign overrun      = overrun_q;
    assign break_det    = brk_q;

endmodule
